// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan driver: digit count, active-low segment codes.
// Pure declarations, no logic.
package display_pkg;
    localparam int NUM_DIGITS = 4;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG7_0 = 7'b1000000;
    localparam logic [6:0] SEG7_1 = 7'b1111001;
    localparam logic [6:0] SEG7_2 = 7'b0100100;
    localparam logic [6:0] SEG7_3 = 7'b0110000;
    localparam logic [6:0] SEG7_4 = 7'b0011001;
    localparam logic [6:0] SEG7_5 = 7'b0010010;
    localparam logic [6:0] SEG7_6 = 7'b0000010;
    localparam logic [6:0] SEG7_7 = 7'b1111000;
    localparam logic [6:0] SEG7_8 = 7'b0000000;
    localparam logic [6:0] SEG7_9 = 7'b0010000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;
endpackage

// File: rtl/seg_scan_driver_if.sv
// Display bus: digit/dp/control inputs toward the driver, active-low AN/SEG pins back.
// No handshake; the driver samples every cycle.
interface seg_scan_driver_if;
    import display_pkg::*;

    logic                        en;
    logic [4*NUM_DIGITS-1:0]     digits;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic                        lz_blank;
    logic [NUM_DIGITS-1:0]       AN;
    logic [7:0]                  SEG;

    modport master (output en, digits, dp_in, lz_blank, input AN, SEG);
    modport slave  (input en, digits, dp_in, lz_blank, output AN, SEG);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment code; 10..15 decode to all segments off.
// Zero latency, no backpressure.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG7_0;
            4'd1:    o_seg = SEG7_1;
            4'd2:    o_seg = SEG7_2;
            4'd3:    o_seg = SEG7_3;
            4'd4:    o_seg = SEG7_4;
            4'd5:    o_seg = SEG7_5;
            4'd6:    o_seg = SEG7_6;
            4'd7:    o_seg = SEG7_7;
            4'd8:    o_seg = SEG7_8;
            4'd9:    o_seg = SEG7_9;
            default: o_seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment driver with per-slot blanking, per-frame snapshot and LZ blanking.
// Pins are registered (1-cycle latency from cnt/idx); no backpressure, pins go dark on en/rst drop.
module seg_scan_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0]              r_cnt;
    logic [1:0]                 r_idx;
    logic [4*NUM_DIGITS-1:0]    r_snap_dig;
    logic [NUM_DIGITS-1:0]      r_snap_dp;
    logic [NUM_DIGITS-1:0]      r_an;
    logic [7:0]                 r_seg;

    logic [3:0]                 w_dig;
    logic [6:0]                 w_seg7;
    logic [NUM_DIGITS-1:0]      w_zero;
    logic                       w_lz_hide;
    logic                       w_show;
    logic                       w_frame_start;
    logic [6:0]                 w_seg_body;

    assign w_dig = r_snap_dig[{r_idx, 2'b00} +: 4];

    bcd_to_seg7 u_bcd_to_seg7 (
        .i_bcd (w_dig),
        .o_seg (w_seg7)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero[i] = (r_snap_dig[4*i +: 4] == 4'd0);
        end
    end

    // A digit is leading only if it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        w_lz_hide = 1'b0;
        case (r_idx)
            2'd3:    w_lz_hide = w_zero[3];
            2'd2:    w_lz_hide = w_zero[3] & w_zero[2];
            2'd1:    w_lz_hide = w_zero[3] & w_zero[2] & w_zero[1];
            default: w_lz_hide = 1'b0;
        endcase
        w_lz_hide = w_lz_hide & bus.lz_blank;
    end

    assign w_show        = (r_cnt >= CNT_BLANK);
    assign w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);
    assign w_seg_body    = w_lz_hide ? SEG_BLANK : w_seg7;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_snap_dig <= '0;
            r_snap_dp  <= '0;
            r_an       <= AN_OFF;
            r_seg      <= 8'hFF;
        end else if (!bus.en) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
            r_an  <= AN_OFF;
            r_seg <= 8'hFF;
        end else begin
            // Snapshot lands during slot 0's blanking, so no shown cycle ever mixes frames.
            if (w_frame_start) begin
                r_snap_dig <= bus.digits;
                r_snap_dp  <= bus.dp_in;
            end

            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_show) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= {~r_snap_dp[r_idx], w_seg_body};
            end else begin
                r_an  <= AN_OFF;
                r_seg <= 8'hFF;
            end
        end
    end

    assign bus.AN  = r_an;
    assign bus.SEG = r_seg;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (8-cycle slots, 2 dark).
// Expected pin values are hand-derived segment codes.
module tb_seg_scan_driver;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one posedge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
        checks++;
        assert (bus.AN === an_exp && bus.SEG === seg_exp)
        else begin
            errors++;
            $error("FAIL %s: AN=%b SEG=%h, expected AN=%b SEG=%h", tag, bus.AN, bus.SEG, an_exp, seg_exp);
        end
    endtask

    // One full slot: 2 dark cycles then 6 lit cycles.
    task automatic slot(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
        for (int i = 0; i < 2; i++) begin
            step();
            chk({tag, "_blank"}, 4'b1111, 8'hFF);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk({tag, "_show"}, an_exp, seg_exp);
        end
    endtask

    // Run a slot up to and including cnt=4, leaving cnt=5 pending (mid-SHOW).
    task automatic partial_slot(input string tag, input logic [3:0] an_exp, input logic [7:0] seg_exp);
        for (int i = 0; i < 2; i++) begin
            step();
            chk({tag, "_blank"}, 4'b1111, 8'hFF);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_show"}, an_exp, seg_exp);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.digits   = 16'h1234;
        bus.dp_in    = 4'b0000;
        bus.lz_blank = 1'b0;

        // 1: reset holds the pins dark
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", 4'b1111, 8'hFF);
        end
        rst = 1'b1;

        // 1-2: two free-running frames of 1234
        for (int f = 0; f < 2; f++) begin
            slot("f1234_s0", 4'b1110, 8'h99);
            slot("f1234_s1", 4'b1101, 8'hB0);
            slot("f1234_s2", 4'b1011, 8'hA4);
            slot("f1234_s3", 4'b0111, 8'hF9);
        end

        // 3: digits change during slot 1; current frame unaffected
        slot("tear_s0", 4'b1110, 8'h99);
        bus.digits = 16'h5678;
        slot("tear_s1", 4'b1101, 8'hB0);
        slot("tear_s2", 4'b1011, 8'hA4);
        slot("tear_s3", 4'b0111, 8'hF9);
        slot("new_s0", 4'b1110, 8'h80);
        slot("new_s1", 4'b1101, 8'hF8);
        slot("new_s2", 4'b1011, 8'h82);
        slot("new_s3", 4'b0111, 8'h92);

        // 4: leading-zero suppression
        bus.lz_blank = 1'b1;
        bus.digits   = 16'h0050;
        slot("lz50_s0", 4'b1110, 8'hC0);
        slot("lz50_s1", 4'b1101, 8'h92);
        slot("lz50_s2", 4'b1011, 8'hFF);
        slot("lz50_s3", 4'b0111, 8'hFF);
        bus.digits = 16'h0000;
        slot("lz00_s0", 4'b1110, 8'hC0);
        slot("lz00_s1", 4'b1101, 8'hFF);
        slot("lz00_s2", 4'b1011, 8'hFF);
        slot("lz00_s3", 4'b0111, 8'hFF);

        // 5: non-BCD digit shows only its decimal point
        bus.lz_blank = 1'b0;
        bus.digits   = 16'h0A00;
        bus.dp_in    = 4'b0100;
        slot("dp_s0", 4'b1110, 8'hC0);
        slot("dp_s1", 4'b1101, 8'hC0);
        slot("dp_s2", 4'b1011, 8'h7F);
        slot("dp_s3", 4'b0111, 8'hC0);
        bus.dp_in = 4'b0000;
        slot("nodp_s0", 4'b1110, 8'hC0);
        slot("nodp_s1", 4'b1101, 8'hC0);
        slot("nodp_s2", 4'b1011, 8'hFF);
        slot("nodp_s3", 4'b0111, 8'hC0);

        // 6a: en drops at slot 2, cnt=5
        bus.digits = 16'h1234;
        slot("en_s0", 4'b1110, 8'h99);
        slot("en_s1", 4'b1101, 8'hB0);
        partial_slot("en_s2", 4'b1011, 8'hA4);
        bus.en = 1'b0;
        step();
        chk("en_drop", 4'b1111, 8'hFF);
        bus.digits = 16'h5678;
        step();
        chk("en_low", 4'b1111, 8'hFF);
        bus.en = 1'b1;
        slot("en_new_s0", 4'b1110, 8'h80);
        slot("en_new_s1", 4'b1101, 8'hF8);

        // 6b: reset asserted mid-SHOW, same dark response and fresh frame after
        partial_slot("rst_s2", 4'b1011, 8'h82);
        rst = 1'b0;
        step();
        chk("rst_drop", 4'b1111, 8'hFF);
        rst        = 1'b1;
        bus.digits = 16'h1234;
        slot("rst_new_s0", 4'b1110, 8'h99);
        slot("rst_new_s1", 4'b1101, 8'hB0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end
endmodule
